fifo_burst_reader: RTL and testbench

- Read-side controller that drains the FIFO's read port (rd_en / empty_n / data_out) in host-requested bursts of N words.
- Accounts for the FIFO's one-cycle read latency with a 2-entry skid buffer.
- Presents data downstream as a valid/ready stream with last-word marking and a completion pulse.
- Sits between the FIFO read port and any rd_clk-domain consumer.

---
 rtl/fifo_burst_reader_pkg.sv | 15 +
 rtl/fifo_burst_skid.sv | 60 ++++++
 rtl/fifo_burst_reader.sv | 184 ++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and default sizing for the FIFO burst reader.
package fifo_burst_reader_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned LEN_W_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_burst_skid.sv
// Two-entry in-order skid buffer; each entry carries data plus a last tag in its MSB.
module fifo_burst_skid #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_entry,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   occ_q, occ_d;

    // slot0 is always the head; simultaneous push/pop keeps occupancy and order
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) slot0_d = push_entry;
                else               slot1_d = push_entry;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    slot0_d = push_entry;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = slot0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO read port in host-requested bursts onto a valid/ready stream.
// Define FIFO_BURST_READER_TIMEOUT_EN to abandon a burst after TIMEOUT empty cycles.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              fifo_empty_n,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  done_count,
    output logic              timeout
);

    localparam int unsigned ENTRY_W = DATA_W + 1;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT must be nonzero");
    end

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   delivered_q, delivered_d;
    logic               pending_q, pending_d;
    logic               pend_last_q, pend_last_d;
    logic               busy_q, busy_d;
    logic               req_ready_q, req_ready_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [LEN_W-1:0]   done_count_q, done_count_d;

    logic [1:0]         occ;
    logic [ENTRY_W-1:0] head;
    logic               pop_c;
    logic               rd_en_c;
    logic [2:0]         fill_c;
    logic               to_hit_c;
    logic               trunc_c;

    fifo_burst_skid #(.W(ENTRY_W)) u_skid (
        .clk        (rd_clk),
        .rst        (rst),
        .push       (pending_q),
        .push_entry ({pend_last_q, fifo_data}),
        .pop        (pop_c),
        .occ        (occ),
        .head       (head)
    );

    assign m_valid = (occ != 2'd0);
    assign m_data  = head[DATA_W-1:0];
    assign m_last  = m_valid && head[DATA_W];
    assign pop_c   = m_valid && m_ready;

    // Issue only if the word cannot overflow the skid when it lands next cycle
    assign fill_c  = 3'(occ) + 3'(pending_q) - 3'(pop_c);
    assign rd_en_c = (state_q == S_READ) && fifo_empty_n &&
                     (remaining_q != '0) && (fill_c < 3'd2);
    assign fifo_rd_en = rd_en_c;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            trunc_q, trunc_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        trunc_d  = trunc_q;
        to_hit_c = 1'b0;
        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
            trunc_d  = 1'b0;
        end else if (state_q == S_READ) begin
            if (rd_en_c) begin
                to_cnt_d = '0;
            end else if (!fifo_empty_n && (remaining_q != '0)) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_d == TO_W'(TIMEOUT)) begin
                    to_hit_c = 1'b1;
                    trunc_d  = 1'b1;
                    to_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            trunc_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            trunc_q  <= trunc_d;
        end
    end

    assign trunc_c = trunc_q;
`else
    assign to_hit_c = 1'b0;
    assign trunc_c  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        delivered_d = delivered_q;
        pending_d   = rd_en_c;
        pend_last_d = rd_en_c && (remaining_q == LEN_W'(1));
        if (pop_c) delivered_d = delivered_q + LEN_W'(1);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    remaining_d = req_len;
                    delivered_d = '0;
                    state_d     = (req_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_en_c) remaining_d = remaining_q - LEN_W'(1);
                if ((remaining_d == '0) || to_hit_c) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if ((occ == 2'd0) && !pending_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of what the next state implies
        busy_d       = (state_d != S_IDLE);
        req_ready_d  = (state_d == S_IDLE);
        done_d       = (state_d == S_DONE);
        done_count_d = done_d ? delivered_d : '0;
        timeout_d    = done_d && trunc_c;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            delivered_q  <= '0;
            pending_q    <= 1'b0;
            pend_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            delivered_q  <= delivered_d;
            pending_q    <= pending_d;
            pend_last_q  <= pend_last_d;
            busy_q       <= busy_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            done_count_q <= done_count_d;
        end
    end

    assign busy       = busy_q;
    assign req_ready  = req_ready_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader with a queue-based FIFO and stream scoreboard.
// Honours FIFO_BURST_READER_TIMEOUT_EN for the starvation scenario.
module tb_fifo_burst_reader;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned TIMEOUT = 8;

    logic              rd_clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [LEN_W-1:0]  req_len;
    logic              fifo_empty_n;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  done_count;
    logic              timeout;

    always #5 rd_clk = ~rd_clk;

    fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_len      (req_len),
        .fifo_empty_n (fifo_empty_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data    (fifo_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .done_count   (done_count),
        .timeout      (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];

    int               cur_len, delivered, rd_cnt, done_cnt, done_step, step_idx;
    int               rd_run, rd_run_max, mode;
    bit               avail, rand_avail, prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [LEN_W-1:0] got_dc;
    logic             got_to;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_for(input int md, input int idx);
        case (md)
            0:       return 1'b1;
            1:       return (idx % 3) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic fill_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty_n = avail && (fifo_q.size() != 0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) fill_word(DATA_W'($urandom));
    endtask

    // One clock: observe at negedge, then update the FIFO model and drive inputs after posedge
    task automatic step();
        bit               rd_now;
        logic [DATA_W-1:0] w;
        @(negedge rd_clk);
        step_idx++;
        rd_now = (fifo_rd_en === 1'b1);
        if (rd_now) begin
            check_eq("rd_nonempty", fifo_q.size() != 0, 1);
            rd_cnt++;
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
        end else begin
            rd_run = 0;
        end
        if (prev_stall) begin
            check_eq("hold_valid", m_valid, 1);
            check_eq("hold_data", m_data, prev_data);
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            delivered++;
            check_eq("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check_eq("data", m_data, w);
            end
            check_eq("last", m_last, delivered == cur_len);
        end
        prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        prev_data  = m_data;
        if (done === 1'b1) begin
            done_cnt++;
            got_dc = done_count;
            got_to = timeout;
            if (done_step < 0) done_step = step_idx;
        end
        @(posedge rd_clk);
        #1;
        if (rd_now && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
        if (rand_avail) avail = ($urandom_range(0, 9) < 8);
        fifo_empty_n = avail && (fifo_q.size() != 0);
        m_ready = ready_for(mode, step_idx);
    endtask

    task automatic run_burst(input int len, input int md, input int exp_dc, input bit exp_to,
                             input int refill_at, input int refill_n, input bit poke);
        mode = md; cur_len = len; delivered = 0; rd_cnt = 0; done_cnt = 0;
        done_step = -1; step_idx = 0; rd_run = 0; rd_run_max = 0;
        got_dc = '0; got_to = 1'b0; prev_stall = 1'b0;
        m_ready = ready_for(mode, 0);
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_len   = LEN_W'(len);
        for (int s = 1; s <= 3000 && done_step < 0; s++) begin
            step();
            req_valid = poke && (s == 3);
            if (poke) req_len = LEN_W'($urandom_range(1, 9));
            if (s == refill_at) fill(refill_n);
        end
        req_valid = 1'b0;
        if (refill_at > 0 && step_idx < refill_at) fill(refill_n);
        for (int i = 0; i < 3; i++) step();
        check_eq("done_pulses", done_cnt, 1);
        check_eq("done_count", got_dc, exp_dc);
        check_eq("timeout", got_to, exp_to);
        check_eq("reads", rd_cnt, exp_dc);
        check_eq("delivered", delivered, exp_dc);
        check_eq("busy_after", busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_len = '0; fifo_empty_n = 1'b0;
        fifo_data = '0; m_ready = 1'b0; avail = 1'b0; rand_avail = 1'b0;
        mode = 3; prev_stall = 1'b0; cur_len = 0; step_idx = 0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_done_count", done_count, 0);

        // Preloaded A0..A3, full-rate drain
        avail = 1'b1;
        fill_word(32'hA0); fill_word(32'hA1); fill_word(32'hA2); fill_word(32'hA3);
        run_burst(4, 0, 4, 0, -1, 0, 0);
        check_eq("rd_back_to_back", rd_run_max, 4);

        // Stalling consumer 1,0,0 pattern
        fill(5);
        run_burst(5, 1, 5, 0, -1, 0, 0);

        // Zero-length burst completes without reads
        run_burst(0, 0, 0, 0, -1, 0, 0);
        check_eq("len0_done_step", done_step, 2);

        // FIFO runs dry after two words, refilled later
        fill(2);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        run_burst(4, 0, 2, 1, 14, 2, 0);
`else
        run_burst(4, 0, 4, 0, 14, 2, 0);
`endif

        // Reset with one word buffered and one in flight
        fill(4);
        mode = 3; m_ready = 1'b0; cur_len = 4; delivered = 0; done_cnt = 0;
        req_valid = 1'b1; req_len = LEN_W'(4);
        step();
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        prev_stall = 1'b0;
        check_eq("mid_rst_m_valid", m_valid, 0);
        check_eq("mid_rst_rd_en", fifo_rd_en, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_req_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) step();
        check_eq("mid_rst_no_done", done_cnt, 0);
        exp_q = fifo_q;
        run_burst(1, 0, 1, 0, -1, 0, 0);

        // Request pulsed while busy must be ignored
        fill(8);
        run_burst(8, 2, 8, 0, -1, 0, 1);

        // Random lengths, random back-pressure and FIFO availability
        rand_avail = 1'b1;
        for (int b = 0; b < 24; b++) begin
            int len;
            len = $urandom_range(0, 20);
            fill(len + $urandom_range(0, 3));
            run_burst(len, $urandom_range(0, 2), len, 0, -1, 0, 0);
        end
        rand_avail = 1'b0;
        avail = 1'b1;

        // Maximum burst length
        fill(255);
        run_burst(255, 0, 255, 0, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
